// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory / writeback stage.
package dmem_pkg;

  typedef enum logic {IDLE, LOAD_WAIT} state_e;

  localparam logic [31:0] MMIO_ADDR  = 32'h0000_FFF0;
  localparam int unsigned WORD_BYTES = 4;

  // Word accesses only: the two byte-offset bits must be clear.
  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Datapath-to-stage bus for mem_wb_stage.
// IoOut is only present when DMEM_MMIO_EN is defined.
interface mem_wb_stage_if;

  logic [31:0] ALU_result;
  logic [31:0] Out2;
  logic        MemWrite;
  logic        MemtoReg;
  logic [31:0] DataToWd;
  logic        Stall;
  logic        WbEn;
  logic        MisalignErr;
`ifdef DMEM_MMIO_EN
  logic [31:0] IoOut;

  modport master (
    output ALU_result, Out2, MemWrite, MemtoReg,
    input  DataToWd, Stall, WbEn, MisalignErr, IoOut
  );

  modport slave (
    input  ALU_result, Out2, MemWrite, MemtoReg,
    output DataToWd, Stall, WbEn, MisalignErr, IoOut
  );
`else
  modport master (
    output ALU_result, Out2, MemWrite, MemtoReg,
    input  DataToWd, Stall, WbEn, MisalignErr
  );

  modport slave (
    input  ALU_result, Out2, MemWrite, MemtoReg,
    output DataToWd, Stall, WbEn, MisalignErr
  );
`endif

endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with a registered read port.
// The read register is reset; the array contents are not.
module dmem_ram #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  // Array write.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  // Read register, updated only when a read is issued.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= 32'h0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_wb_stage.sv
// Data-memory and writeback stage following the single-cycle MIPS datapath.
// Loads take two cycles (stall in the first), stores one. Misaligned accesses
// are dropped and raise a sticky error flag.
// Optional: define DMEM_MMIO_EN to map an output register at MMIO_ADDR.
module mem_wb_stage
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic          Clock,
  input  logic          Reset,
  mem_wb_stage_if.slave bus
);

  localparam int unsigned OffW = $clog2(WORD_BYTES);

  state_e              state_q;
  logic                err_q;
  logic                aligned;
  logic                in_idle;
  logic                is_mmio;
  logic                store_go;
  logic                load_go;
  logic                misalign;
  logic [ADDR_W-1:0]   word_idx;
  logic [31:0]         ram_rdata;
  logic [31:0]         load_data;

  assign aligned  = is_aligned(bus.ALU_result);
  assign word_idx = bus.ALU_result[ADDR_W+OffW-1:OffW];
  assign in_idle  = (state_q == IDLE);

  // Accesses are only accepted in IDLE; a store wins over a simultaneous load.
  assign store_go = in_idle & bus.MemWrite & aligned;
  assign load_go  = in_idle & bus.MemtoReg & ~bus.MemWrite & aligned;
  assign misalign = in_idle & (bus.MemWrite | bus.MemtoReg) & ~aligned;

`ifdef DMEM_MMIO_EN
  logic [31:0] io_q;
  logic        mmio_rd_q;

  assign is_mmio = (bus.ALU_result == MMIO_ADDR);

  // MMIO output register and the source select for the pending load.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      io_q      <= 32'h0;
      mmio_rd_q <= 1'b0;
    end else begin
      if (store_go && is_mmio) io_q <= bus.Out2;
      mmio_rd_q <= load_go & is_mmio;
    end
  end

  assign bus.IoOut = io_q;
  assign load_data = mmio_rd_q ? io_q : ram_rdata;
`else
  assign is_mmio   = 1'b0;
  assign load_data = ram_rdata;
`endif

  dmem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .we_i    (store_go & ~is_mmio),
    .re_i    (load_go & ~is_mmio),
    .addr_i  (word_idx),
    .wdata_i (bus.Out2),
    .rdata_o (ram_rdata)
  );

  // Load FSM and sticky misalignment flag.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= load_go ? LOAD_WAIT : IDLE;
      if (misalign) err_q <= 1'b1;
    end
  end

  // Writeback data select; a launching load's value is masked by WbEn anyway.
  always_comb begin
    bus.DataToWd = bus.ALU_result;
    if (!in_idle) begin
      bus.DataToWd = load_data;
    end else if (bus.MemtoReg && (!bus.MemWrite || !aligned)) begin
      bus.DataToWd = 32'h0;
    end
  end

  assign bus.Stall       = load_go;
  assign bus.WbEn        = ~load_go;
  assign bus.MisalignErr = err_q;

endmodule
